// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared state encoding and default sizes for the RAM burst master.
package ram_master_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_LEN_W  = 5;
endpackage

// File: rtl/ram_burst_counter.sv
// ram_burst_counter: burst start load, mod-DEPTH address stepping and beats-remaining flags.
module ram_burst_counter #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 32,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              empty_o,
   output logic              last_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] cur_q, cur_d;
   logic [LEN_W:0] left_q, left_d;
   // address wraps DEPTH-1 -> 0 purely by truncation to AW bits
   always_comb begin
      cur_d  = load_i ? addr_i[AW-1:0] : step_i ? cur_q + AW'(1) : cur_q;
      left_d = load_i ? {1'b0, len_i} + (LEN_W+1)'(1) : step_i ? left_q - (LEN_W+1)'(1) : left_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q  <= '0;
         left_q <= '0;
      end else begin
         cur_q  <= cur_d;
         left_q <= left_d;
      end
   end
   assign addr_o  = ADDR_W'(cur_q);
   assign empty_o = left_q == '0;
   assign last_o  = left_q == (LEN_W+1)'(1);
endmodule

// File: rtl/single_port_ram_master.sv
// single_port_ram_master: burst command initiator for one single_port_ram, with
// a streamed write path and a one-deep registered read response.
module single_port_ram_master
   import ram_master_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_en,
   output logic              ram_write_enable,
   input  logic [DATA_W-1:0] ram_q
);
   state_t state_q, state_d;
   logic pend_q, pend_d, rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] last_q, last_d, cnt_addr;
   logic cnt_empty, cnt_last, take, issue;
   assign take  = pend_q && (!rd_valid_q || rd_ready);
   assign issue = state_q == READ && !cnt_empty && (!pend_q || take);
   ram_burst_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load_i  (cmd_valid && cmd_ready),
      .addr_i  (cmd_addr),
      .len_i   (cmd_len),
      .step_i  ((state_q == WRITE && wr_valid) || issue),
      .addr_o  (cnt_addr),
      .empty_o (cnt_empty),
      .last_o  (cnt_last)
   );
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end
   // a read burst ends when the final pending beat is captured; nothing is left to issue then
   always_comb begin
      state_d = state_q == IDLE  ? (cmd_valid ? (cmd_write ? WRITE : READ) : IDLE) :
                state_q == WRITE ? (wr_valid && cnt_last ? IDLE : WRITE) :
                                   (take && cnt_empty ? IDLE : READ);
   end
   always_comb begin
      busy             = !rst && state_q != IDLE;
      cmd_ready        = !rst && state_q == IDLE;
      wr_ready         = !rst && state_q == WRITE;
      ram_en           = !rst && (state_q == WRITE ? wr_valid : state_q == READ);
      ram_write_enable = !rst && state_q == WRITE;
      ram_address      = state_q == READ && !issue ? last_q : cnt_addr;
      ram_data         = wr_data;
   end
   // while stalled, re-presenting the last issued address keeps ram_q steady
   always_comb begin
      pend_d     = issue ? 1'b1 : take ? 1'b0 : pend_q;
      rd_valid_d = take ? 1'b1 : rd_ready ? 1'b0 : rd_valid_q;
      rd_data_d  = take ? ram_q : rd_data_q;
      last_d     = issue ? cnt_addr : last_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         last_q     <= '0;
      end else begin
         pend_q     <= pend_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         last_q     <= last_d;
      end
   end
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_single_port_ram_master.sv
// tb_single_port_ram_master: drives bursts into the master with a behavioural
// single-port RAM attached and checks against a plain array model of RAM contents.
module tb_single_port_ram_master;
   localparam int DW = 8;
   localparam int AW = 6;
   localparam int D  = 32;
   localparam int LW = 5;

   logic clk = 1'b0;
   logic rst, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, rd_ready, busy;
   logic ram_en, ram_write_enable;
   logic [AW-1:0] cmd_addr, ram_address;
   logic [LW-1:0] cmd_len;
   logic [DW-1:0] wr_data, rd_data, ram_data, ram_q;

   always #5 clk = ~clk;

   single_port_ram_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy),
      .ram_data(ram_data), .ram_address(ram_address), .ram_en(ram_en),
      .ram_write_enable(ram_write_enable), .ram_q(ram_q)
   );

   // responder RAM: registered address, q undefined (poisoned) unless reading
   logic [DW-1:0] mem [D];
   logic [AW-1:0] areg = '0;
   initial for (int i = 0; i < D; i++) mem[i] = '0;
   always @(posedge clk) if (ram_en) begin
      if (ram_write_enable) mem[ram_address[4:0]] <= ram_data;
      areg <= ram_address;
   end
   assign ram_q = (ram_en && !ram_write_enable) ? mem[areg[4:0]] : 8'hEE;

   int nchk = 0, nfail = 0;
   logic [DW-1:0] ref_mem [D];

   typedef struct { bit w; int a; int l; int base; int step; int gap; int mode; int exp; } vec_t;
   vec_t tbl [9];

   task automatic chk(input string n, input int got, input int exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic send_cmd(input bit w, input int a, input int l);
      bit done;
      done = 0;
      cmd_valid = 1; cmd_write = w; cmd_addr = AW'(a); cmd_len = LW'(l);
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk);
         if (cmd_ready) done = 1;
         @(posedge clk); #1;
      end
      cmd_valid = 0;
      chk("cmd_accept", int'(done), 1);
   endtask

   task automatic do_write(input int a, input int l, input int base, input int step, input int gap,
                           output int last_addr);
      int g;
      last_addr = -1;
      send_cmd(1, a, l);
      for (int i = 0; i <= l; i++) begin
         g = gap < 0 ? int'($urandom_range(2)) : gap;
         wr_valid = 0;
         for (int k = 0; k < g; k++) begin
            @(negedge clk);
            chk("gap_en", int'(ram_en), 0);
            chk("gap_cmd_ready", int'(cmd_ready), 0);
            @(posedge clk); #1;
         end
         wr_valid = 1; wr_data = DW'(base + i * step);
         @(negedge clk);
         chk("wr_ready", int'(wr_ready), 1);
         chk("wr_en_we", int'({ram_en, ram_write_enable}), 3);
         chk("wr_addr", int'(ram_address), (a + i) % D);
         chk("wr_cmd_ready", int'(cmd_ready), 0);
         last_addr = int'(ram_address);
         ref_mem[(a + i) % D] = DW'(base + i * step);
         @(posedge clk); #1;
      end
      wr_valid = 0;
      @(negedge clk);
      chk("wr_done_ready", int'(cmd_ready), 1);
      chk("wr_done_busy", int'(busy), 0);
      @(posedge clk); #1;
   endtask

   // mode 0: rd_ready always 1, 1: toggling, 2: random
   task automatic do_read(input int a, input int l, input int mode, output int first_data);
      int got, cyc;
      bit stall_prev;
      logic [DW-1:0] q_prev;
      got = 0; cyc = 0; stall_prev = 0; q_prev = '0; first_data = -1;
      send_cmd(0, a, l);
      while (got <= l && cyc < 200) begin
         cyc++;
         rd_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(1));
         @(negedge clk);
         if (busy) chk("rd_en", int'({ram_en, ram_write_enable}), 2);
         if (stall_prev && busy) chk("stall_q", int'(ram_q), int'(q_prev));
         stall_prev = busy && rd_valid && !rd_ready;
         q_prev = ram_q;
         if (rd_valid && rd_ready) begin
            if (got == 0) first_data = int'(rd_data);
            chk("rd_data", int'(rd_data), int'(ref_mem[(a + got) % D]));
            if (mode == 0) chk("rd_cycle", cyc, 3 + got);
            if (got == l) chk("rd_done_busy", int'(busy), 0);
            got++;
         end
         @(posedge clk); #1;
      end
      rd_ready = 0;
      chk("rd_count", got, l + 1);
   endtask

   initial begin
      int r, n;
      tbl[0] = '{1,  5, 3, 'h11, 'h11, 0, 0, 8};
      tbl[1] = '{0,  5, 3, 0,    0,    0, 0, 'h11};
      tbl[2] = '{0,  5, 3, 0,    0,    0, 1, 'h11};
      tbl[3] = '{1, 30, 3, 'hA0, 1,    0, 0, 1};
      tbl[4] = '{0, 30, 3, 0,    0,    0, 0, 'hA0};
      tbl[5] = '{1, 10, 2, 'h50, 1,    2, 0, 12};
      tbl[6] = '{0, 10, 2, 0,    0,    0, 2, 'h50};
      tbl[7] = '{1, 40, 0, 'h77, 0,    0, 0, 8};
      tbl[8] = '{0,  8, 0, 0,    0,    0, 0, 'h77};
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 0; wr_data = '0; rd_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_outputs", int'({cmd_ready, busy, wr_ready, ram_en, ram_write_enable, rd_valid}), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].w) begin
            do_write(tbl[i].a, tbl[i].l, tbl[i].base, tbl[i].step, tbl[i].gap, r);
            chk("vec_last_addr", r, tbl[i].exp);
         end else begin
            do_read(tbl[i].a, tbl[i].l, tbl[i].mode, r);
            chk("vec_first_data", r, tbl[i].exp);
         end
      end

      // reset in the middle of a read burst
      send_cmd(0, 0, 7);
      rd_ready = 1; n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         @(negedge clk);
         if (rd_valid) begin
            chk("pre_rst_data", int'(rd_data), int'(ref_mem[n]));
            n++;
         end
         @(posedge clk); #1;
      end
      chk("pre_rst_beats", n, 2);
      rst = 1;
      @(negedge clk);
      chk("mid_rst_ram_en", int'(ram_en), 0);
      chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("after_rst_state", int'({rd_valid, busy, cmd_ready}), 1);
      @(posedge clk); #1;
      rd_ready = 0;
      do_read(0, 0, 0, r);
      chk("after_rst_read", r, 'hA2);

      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(1) == 1)
            do_write(int'($urandom_range(63)), int'($urandom_range(7)), int'($urandom_range(255)),
                     int'($urandom_range(255)), -1, r);
         else
            do_read(int'($urandom_range(63)), int'($urandom_range(7)), 2, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
